// File: rtl/ptlut_sched_pkg.sv
// Shared types for the PT LUT request scheduler: default-width entry
// struct, FSM state enum and the tag/index width helpers.
package ptlut_sched_pkg;

    localparam int NTRK_DEF = 3;
    localparam int AW_DEF   = 30;
    localparam int CSW_DEF  = 32;
    localparam int BXW_DEF  = 12;

    typedef struct packed {
        logic [NTRK_DEF-1:0][AW_DEF-1:0]  addr;
        logic [NTRK_DEF-1:0][CSW_DEF-1:0] cs;
        logic [NTRK_DEF-1:0]              mask;
        logic [BXW_DEF-1:0]               bx;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic int idx_w(input int ntrk);
        return (ntrk > 1) ? $clog2(ntrk) : 1;
    endfunction

    function automatic int tag_w(input int ntrk, input int bxw);
        return bxw + idx_w(ntrk);
    endfunction

endpackage

// File: rtl/ptlut_req_sched_if.sv
// PT LUT request port: address, chip select, {bx,track} tag, valid
// (master drives) and ready (slave drives).
interface ptlut_req_sched_if #(
    parameter int AW  = 30,
    parameter int CSW = 32,
    parameter int TW  = ptlut_sched_pkg::tag_w(
        ptlut_sched_pkg::NTRK_DEF, ptlut_sched_pkg::BXW_DEF)
);
    logic [AW-1:0]  lut_addr;
    logic [CSW-1:0] lut_cs;
    logic [TW-1:0]  lut_tag;
    logic           lut_val;
    logic           lut_rdy;

    modport master (
        output lut_addr, lut_cs, lut_tag, lut_val,
        input  lut_rdy
    );

    modport slave (
        input  lut_addr, lut_cs, lut_tag, lut_val,
        output lut_rdy
    );
endinterface

// File: rtl/ptlut_sched_fifo.sv
// Show-ahead FIFO with simultaneous push/pop and occupancy count.
// Ports: push_i/wdata_i write, pop_i read, head_o/next_o, cnt_o.
module ptlut_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           head_o,
    output logic [W-1:0]           next_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] wptr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o = mem_q[rptr_q];
    assign next_o = mem_q[rptr_q + PW'(1)];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/ptlut_req_sched.sv
// PT LUT request scheduler: buffers per-BX track sets and issues valid
// tracks one at a time on the lut port, tagged {bx, track index}.
// Ports: clk, rst, bc0, in_addr/in_cs/in_val (set input), lut (master
// request port), busy, fifo_cnt, ovf, ovf_cnt, hwm.
// PTLUT_SCHED_STATS_EN builds ovf_cnt and hwm; otherwise they read 0.
module ptlut_req_sched
    import ptlut_sched_pkg::*;
#(
    parameter int NTRK  = 3,
    parameter int AW    = 30,
    parameter int CSW   = 32,
    parameter int DEPTH = 8,
    parameter int BXW   = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bc0,
    input  logic [NTRK-1:0][AW-1:0]     in_addr,
    input  logic [NTRK-1:0][CSW-1:0]    in_cs,
    input  logic [NTRK-1:0]             in_val,
    ptlut_req_sched_if.master           lut,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      fifo_cnt,
    output logic                        ovf,
    output logic [15:0]                 ovf_cnt,
    output logic [$clog2(DEPTH):0]      hwm
);
    localparam int IW = idx_w(NTRK);
    localparam int TW = tag_w(NTRK, BXW);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [NTRK-1:0][AW-1:0]  addr;
        logic [NTRK-1:0][CSW-1:0] cs;
        logic [NTRK-1:0]          mask;
        logic [BXW-1:0]           bx;
    } ent_t;

    ent_t           wr_ent, head, nxt, src;
    logic [CW-1:0]  cnt, cnt_d;
    logic           push, pop, drop, go;
    logic [NTRK-1:0] msk, rem_q, rem_d;
    logic [IW-1:0]  li;
    logic [AW-1:0]  addr_q, addr_d;
    logic [CSW-1:0] cs_q, cs_d;
    logic [TW-1:0]  tag_q, tag_d;
    state_t         state_q, state_d;
    logic [BXW-1:0] bx_q;
    logic           ovf_q, busy_q;

    function automatic logic [IW-1:0] low_idx(input logic [NTRK-1:0] m);
        low_idx = '0;
        for (int i = NTRK - 1; i >= 0; i--) begin
            if (m[i]) low_idx = IW'(i);
        end
    endfunction

    assign wr_ent = '{addr: in_addr, cs: in_cs, mask: in_val, bx: bx_q};

    // A set is taken while full only if the head retires this edge.
    assign push  = (|in_val) && ((cnt < CW'(DEPTH)) || pop);
    assign drop  = (|in_val) && !push;
    assign cnt_d = cnt + CW'(push) - CW'(pop);

    ptlut_sched_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_ent),
        .head_o  (head),
        .next_o  (nxt),
        .cnt_o   (cnt)
    );

    // The entry being issued stays at the FIFO head until its last
    // track is accepted; rem_q holds the tracks not yet issued.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        cs_d    = cs_q;
        tag_d   = tag_q;
        pop     = 1'b0;
        go      = 1'b0;
        src     = head;
        msk     = rem_q;
        unique case (state_q)
            IDLE: begin
                if (cnt != '0) begin
                    go      = 1'b1;
                    msk     = head.mask;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (lut.lut_rdy) begin
                    if (rem_q != '0) begin
                        go = 1'b1;
                    end else begin
                        pop = 1'b1;
                        if (cnt > CW'(1)) begin
                            go  = 1'b1;
                            src = nxt;
                            msk = nxt.mask;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase
        li = low_idx(msk);
        if (go) begin
            rem_d  = msk & ~(NTRK'(1) << li);
            addr_d = src.addr[li];
            cs_d   = src.cs[li];
            tag_d  = {src.bx, li};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            cs_q    <= '0;
            tag_q   <= '0;
            bx_q    <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            tag_q   <= tag_d;
            bx_q    <= bc0 ? '0 : bx_q + BXW'(1);
            ovf_q   <= ovf_q | drop;
            busy_q  <= (cnt_d != '0) || (state_d != IDLE);
        end
    end

`ifdef PTLUT_SCHED_STATS_EN
    logic [15:0]   ovfc_q;
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovfc_q <= '0;
            hwm_q  <= '0;
        end else begin
            if (drop && (ovfc_q != 16'hFFFF)) begin
                ovfc_q <= ovfc_q + 16'd1;
            end
            if (cnt_d > hwm_q) begin
                hwm_q <= cnt_d;
            end
        end
    end

    assign ovf_cnt = ovfc_q;
    assign hwm     = hwm_q;
`else
    assign ovf_cnt = '0;
    assign hwm     = '0;
`endif

    assign lut.lut_val  = (state_q == ISSUE);
    assign lut.lut_addr = addr_q;
    assign lut.lut_cs   = cs_q;
    assign lut.lut_tag  = tag_q;
    assign busy         = busy_q;
    assign fifo_cnt     = cnt;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_ptlut_req_sched.sv
// Bench for ptlut_req_sched: directed scenarios plus random traffic,
// all checked each cycle against a queue-based request model.
module tb_ptlut_req_sched;
    localparam int NTRK  = 3;
    localparam int AW    = 30;
    localparam int CSW   = 32;
    localparam int DEPTH = 8;
    localparam int BXW   = 4;
    localparam int TW    = 6;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  bc0 = 1'b0;
    logic                  rdy = 1'b0;
    logic [2:0][AW-1:0]    in_addr = '0;
    logic [2:0][CSW-1:0]   in_cs = '0;
    logic [2:0]            in_val = '0;
    logic                  busy, ovf;
    logic [3:0]            fifo_cnt, hwm;
    logic [15:0]           ovf_cnt;

    ptlut_req_sched_if #(.AW(AW), .CSW(CSW), .TW(TW)) lut_if ();
    assign lut_if.lut_rdy = rdy;

    ptlut_req_sched #(
        .NTRK(NTRK), .AW(AW), .CSW(CSW), .DEPTH(DEPTH), .BXW(BXW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bc0      (bc0),
        .in_addr  (in_addr),
        .in_cs    (in_cs),
        .in_val   (in_val),
        .lut      (lut_if),
        .busy     (busy),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf),
        .ovf_cnt  (ovf_cnt),
        .hwm      (hwm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][AW-1:0]  a;
        logic [2:0][CSW-1:0] c;
        logic [2:0]          m;
        logic [3:0]          bx;
    } ment_t;

    int    n_tests = 0;
    int    n_fail = 0;
    ment_t mq[$];
    ment_t cur;
    int    pend[$];
    int    midx = 0;
    bit    mval = 0;
    int    mb = 0;
    int    mhwm = 0;
    int    movc = 0;
    bit    movf = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start();
        cur = mq[0];
        pend.delete();
        for (int i = 0; i < 3; i++) if (cur.m[i]) pend.push_back(i);
        midx = pend.pop_front();
        mval = 1;
    endtask

    task automatic model_edge();
        bit pr, pp, acc;
        ment_t e;
        if (rst) begin
            mq.delete(); pend.delete();
            mval = 0; mb = 0; movf = 0; movc = 0; mhwm = 0;
            return;
        end
        pr  = (in_val != 0);
        pp  = mval && rdy && (pend.size() == 0);
        acc = pr && ((mq.size() < DEPTH) || pp);
        if (mval && rdy && pend.size() > 0) begin
            midx = pend.pop_front();
        end else if (pp) begin
            void'(mq.pop_front());
            if (mq.size() > 0) start();
            else mval = 0;
        end else if (!mval && mq.size() > 0) begin
            start();
        end
        if (acc) begin
            e.a = in_addr; e.c = in_cs; e.m = in_val; e.bx = 4'(mb);
            mq.push_back(e);
        end else if (pr) begin
            movf = 1;
            if (movc < 65535) movc++;
        end
        mb = bc0 ? 0 : (mb + 1) % 16;
        if (mq.size() > mhwm) mhwm = mq.size();
    endtask

    task automatic compare();
        chk("lut_val", 64'(lut_if.lut_val), 64'(mval));
        if (mval) begin
            chk("lut_addr", 64'(lut_if.lut_addr), 64'(cur.a[midx]));
            chk("lut_cs", 64'(lut_if.lut_cs), 64'(cur.c[midx]));
            chk("lut_tag", 64'(lut_if.lut_tag), 64'({cur.bx, 2'(midx)}));
        end
        chk("fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
        chk("busy", 64'(busy), 64'(mq.size() != 0));
        chk("ovf", 64'(ovf), 64'(movf));
`ifdef PTLUT_SCHED_STATS_EN
        chk("ovf_cnt", 64'(ovf_cnt), 64'(movc));
        chk("hwm", 64'(hwm), 64'(mhwm));
`else
        chk("ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("hwm", 64'(hwm), 64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(logic [2:0] v, logic r, logic b);
        in_val = v; rdy = r; bc0 = b;
        for (int i = 0; i < 3; i++) begin
            in_addr[i] = AW'($urandom);
            in_cs[i]   = $urandom;
        end
    endtask

    initial begin
        logic [AW-1:0] a0, a2;

        rst = 1'b1;
        drive(3'b000, 1'b1, 1'b0);
        step(); step();
        chk("rst_addr", 64'(lut_if.lut_addr), 64'd0);
        chk("rst_tag", 64'(lut_if.lut_tag), 64'd0);
        chk("rst_cnt", 64'(fifo_cnt), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 20 && mb != 5; k++) begin
            drive(3'b000, 1'b1, 1'b0); step();
        end
        drive(3'b101, 1'b1, 1'b0);
        a0 = in_addr[0]; a2 = in_addr[2];
        step();
        chk("single_cnt", 64'(fifo_cnt), 64'd1);
        chk("single_noval", 64'(lut_if.lut_val), 64'd0);
        drive(3'b000, 1'b1, 1'b0); step();
        chk("single_val0", 64'(lut_if.lut_val), 64'd1);
        chk("single_tag0", 64'(lut_if.lut_tag), 64'd20);
        chk("single_addr0", 64'(lut_if.lut_addr), 64'(a0));
        step();
        chk("single_tag2", 64'(lut_if.lut_tag), 64'd22);
        chk("single_addr2", 64'(lut_if.lut_addr), 64'(a2));
        step();
        chk("single_idle", 64'(lut_if.lut_val), 64'd0);
        chk("single_busy", 64'(busy), 64'd0);

        drive(3'b111, 1'b0, 1'b0);
        a0 = in_addr[0];
        step();
        drive(3'b000, 1'b0, 1'b0); step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_addr", 64'(lut_if.lut_addr), 64'(a0));
            chk("bp_val", 64'(lut_if.lut_val), 64'd1);
        end
        drive(3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step();

        drive(3'b010, 1'b0, 1'b0); step();
        for (int k = 0; k < 9; k++) begin
            drive(3'($urandom_range(1, 7)), 1'b0, 1'b0); step();
        end
        chk("ovf_full", 64'(fifo_cnt), 64'd8);
        chk("ovf_flag", 64'(ovf), 64'd1);
`ifdef PTLUT_SCHED_STATS_EN
        chk("ovf_cnt_lit", 64'(ovf_cnt), 64'd2);
        chk("hwm_lit", 64'(hwm), 64'd8);
`endif
        drive(3'b001, 1'b1, 1'b0); step();
        chk("fullpop_cnt", 64'(fifo_cnt), 64'd8);
`ifdef PTLUT_SCHED_STATS_EN
        chk("fullpop_ovfc", 64'(ovf_cnt), 64'd2);
`endif
        drive(3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step();
        chk("drain_cnt", 64'(fifo_cnt), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);

        drive(3'b111, 1'b0, 1'b0); step();
        drive(3'b011, 1'b0, 1'b0); step();
        drive(3'b100, 1'b0, 1'b0); step();
        chk("pre_rst_val", 64'(lut_if.lut_val), 64'd1);
        rst = 1'b1;
        drive(3'b000, 1'b0, 1'b0); step();
        rst = 1'b0;
        chk("mid_rst_val", 64'(lut_if.lut_val), 64'd0);
        chk("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);

        for (int k = 0; k < 20 && mb != 15; k++) begin
            drive(3'b000, 1'b1, 1'b0); step();
        end
        drive(3'b001, 1'b1, 1'b0); step();
        drive(3'b001, 1'b1, 1'b0); step();
        chk("wrap_tag15", 64'(lut_if.lut_tag), 64'd60);
        drive(3'b000, 1'b1, 1'b0); step();
        chk("wrap_tag0", 64'(lut_if.lut_tag), 64'd0);
        step();

        for (int k = 0; k < 20 && mb != 9; k++) begin
            drive(3'b000, 1'b1, 1'b0); step();
        end
        drive(3'b000, 1'b1, 1'b1); step();
        drive(3'b100, 1'b1, 1'b0); step();
        drive(3'b000, 1'b1, 1'b0); step();
        chk("bc0_val", 64'(lut_if.lut_val), 64'd1);
        chk("bc0_tag", 64'(lut_if.lut_tag), 64'd2);
        step();

        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 49) == 0));
            step();
        end
        rst = 1'b0;
        drive(3'b000, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
